// File: rtl/spi_adc_scanner_if.sv
// Shared SPI bus of the ADC scanner: one sck/sdo pair plus one active-low select per device.
interface spi_adc_scanner_if #(
  parameter int unsigned CHANNELS = 1
);
  logic [CHANNELS-1:0] ncs;
  logic                sck;
  logic                sdo;

  modport master (output ncs, output sck, input sdo);
  modport slave  (input ncs, input sck, output sdo);
endinterface

// File: rtl/spi_adc_scanner.sv
// Round-robin SPI ADC reader: frames each device in turn on a shared bus and latches a
// DATA_W-bit field of every frame into that channel's slice of the result bus.
module spi_adc_scanner #(
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned CLK_DIV     = 25,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned DATA_MSB    = 12,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned QUIET_TICKS = 6,
  parameter int unsigned CONTINUOUS  = 1,
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       trigger,
  spi_adc_scanner_if.master          spi,
  output logic [CHANNELS*DATA_W-1:0] data,
  output logic                       sample_valid,
  output logic [CH_W-1:0]            sample_ch,
  output logic                       busy
);
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);
  localparam int unsigned QT_W  = $clog2(QUIET_TICKS + 1);
  localparam int unsigned SW_W  = $clog2(CHANNELS + 1);
  localparam int unsigned SR_W  = DATA_MSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_LATCH,
    ST_QUIET
  } state_e;

  state_e                     state_q, state_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [CH_W-1:0]            ptr_q, ptr_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [QT_W-1:0]            quiet_q, quiet_d;
  logic [SW_W-1:0]            sweep_q, sweep_d;
  logic [SR_W-1:0]            shreg_q, shreg_d;
  logic [CHANNELS-1:0]        ncs_q, ncs_d;
  logic                       sck_q, sck_d;
  logic [CHANNELS*DATA_W-1:0] data_q, data_d;
  logic                       valid_q, valid_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic                       busy_q, busy_d;

  logic tick;
  logic start;
  logic resume;

  assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
  assign start  = enable && ((CONTINUOUS != 0) || trigger);
  assign resume = enable && ((CONTINUOUS != 0) || (sweep_q < SW_W'(CHANNELS)));

  // Next-state and datapath; sck stays high for one extra tick after SETUP so the
  // frame spans 2*FRAME_BITS+2 ticks from ncs falling to the latch.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ptr_d   = ptr_q;
    bit_d   = bit_q;
    quiet_d = quiet_q;
    sweep_d = sweep_q;
    shreg_d = shreg_q;
    ncs_d   = ncs_q;
    sck_d   = sck_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ch_d    = ch_q;
    busy_d  = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        sck_d = 1'b1;
        if (start) begin
          state_d = ST_SETUP;
          sweep_d = '0;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          bit_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (sck_q) begin
            if (bit_q == BIT_W'(FRAME_BITS)) begin
              state_d = ST_LATCH;
              data_d[32'(ptr_q) * DATA_W +: DATA_W] = shreg_q[DATA_MSB -: DATA_W];
              valid_d = 1'b1;
              ch_d    = ptr_q;
              ptr_d   = (ptr_q == CH_W'(CHANNELS - 1)) ? '0 : ptr_q + CH_W'(1);
              sweep_d = sweep_q + SW_W'(1);
            end else begin
              sck_d = 1'b0;
            end
          end else begin
            shreg_d = SR_W'({shreg_q, spi.sdo});
            sck_d   = 1'b1;
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      ST_LATCH: begin
        state_d = ST_QUIET;
        quiet_d = '0;
      end
      ST_QUIET: begin
        if (tick) begin
          if (quiet_q == QT_W'(QUIET_TICKS - 1)) begin
            state_d = resume ? ST_SETUP : ST_IDLE;
          end else begin
            quiet_d = quiet_q + QT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Divider parks at zero in IDLE and LATCH so QUIET starts on a fresh tick.
    div_d  = (state_q == ST_IDLE || state_q == ST_LATCH || tick) ? '0 : div_q + DIV_W'(1);
    ncs_d  = (state_d == ST_SETUP || state_d == ST_SHIFT) ? ~(CHANNELS'(1) << ptr_d) : '1;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      ptr_q   <= '0;
      bit_q   <= '0;
      quiet_q <= '0;
      sweep_q <= '0;
      shreg_q <= '0;
      ncs_q   <= '1;
      sck_q   <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ptr_q   <= ptr_d;
      bit_q   <= bit_d;
      quiet_q <= quiet_d;
      sweep_q <= sweep_d;
      shreg_q <= shreg_d;
      ncs_q   <= ncs_d;
      sck_q   <= sck_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      busy_q  <= busy_d;
    end
  end

  assign spi.ncs      = ncs_q;
  assign spi.sck      = sck_q;
  assign data         = data_q;
  assign sample_valid = valid_q;
  assign sample_ch    = ch_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_spi_adc_scanner.sv
// Directed bench: one free-running scanner and one triggered scanner, each on its own
// two-device bus model, checked with immediate assertions against hand-computed values.
module tb_spi_adc_scanner;
  localparam int unsigned CH = 2;
  localparam logic [15:0] FT0 = 16'h14A0;
  localparam logic [15:0] FT1 = 16'h0BE0;

  logic        clk;
  logic        rst_n;
  logic        en_c, en_t, trig_c, trig_t;
  logic [15:0] data_c, data_t;
  logic        valid_c, valid_t;
  logic [0:0]  ch_c, ch_t;
  logic        busy_c, busy_t;

  spi_adc_scanner_if #(.CHANNELS(CH)) bus_c ();
  spi_adc_scanner_if #(.CHANNELS(CH)) bus_t ();

  spi_adc_scanner #(
    .CHANNELS(CH), .CLK_DIV(4), .FRAME_BITS(16), .DATA_MSB(12), .DATA_W(8),
    .QUIET_TICKS(6), .CONTINUOUS(1)
  ) u_cont (
    .clk(clk), .rst_n(rst_n), .enable(en_c), .trigger(trig_c), .spi(bus_c),
    .data(data_c), .sample_valid(valid_c), .sample_ch(ch_c), .busy(busy_c)
  );

  spi_adc_scanner #(
    .CHANNELS(CH), .CLK_DIV(4), .FRAME_BITS(16), .DATA_MSB(12), .DATA_W(8),
    .QUIET_TICKS(6), .CONTINUOUS(0)
  ) u_trig (
    .clk(clk), .rst_n(rst_n), .enable(en_t), .trigger(trig_t), .spi(bus_t),
    .data(data_t), .sample_valid(valid_t), .sample_ch(ch_t), .busy(busy_t)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Device models: shift the selected device's frame MSB first on each falling sck.
  logic [15:0] fc0 = FT0;
  logic [15:0] fc1 = FT1;
  int          c_bit = 0;
  int          t_bit = 0;
  logic [15:0] c_frame, t_frame;

  always @(negedge bus_c.sck) begin
    if (bus_c.ncs != 2'b11 && c_bit < 16) begin
      c_frame   = bus_c.ncs[0] ? fc1 : fc0;
      bus_c.sdo = c_frame[4'(15 - c_bit)];
      c_bit++;
    end
  end
  always @(bus_c.ncs) if (bus_c.ncs == 2'b11) c_bit = 0;

  always @(negedge bus_t.sck) begin
    if (bus_t.ncs != 2'b11 && t_bit < 16) begin
      t_frame   = bus_t.ncs[0] ? FT1 : FT0;
      bus_t.sdo = t_frame[4'(15 - t_bit)];
      t_bit++;
    end
  end
  always @(bus_t.ncs) if (bus_t.ncs == 2'b11) t_bit = 0;

  // Bus observer for the free-running scanner.
  logic [1:0] p_ncs = 2'b11;
  logic       p_sck = 1'b1;
  int sck_edges = 0, win_rises = 0, windows = 0, bad_win = 0, ncs00 = 0, viol = 0;
  int fall_cyc = 0, fall_prev = 0, c_vcnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_c.sck != p_sck) sck_edges++;
      if (bus_c.ncs == 2'b00) ncs00++;
      if (bus_c.ncs != p_ncs && !(bus_c.sck && p_sck)) viol++;
      if (bus_c.sck && !p_sck && bus_c.ncs != 2'b11) win_rises++;
      if (p_ncs == 2'b11 && bus_c.ncs != 2'b11) begin
        fall_prev = fall_cyc;
        fall_cyc  = cyc;
        win_rises = 0;
      end
      if (p_ncs != 2'b11 && bus_c.ncs == 2'b11) begin
        windows++;
        if (win_rises != 16) bad_win++;
      end
      if (valid_c) c_vcnt++;
    end
    p_ncs = bus_c.ncs;
    p_sck = bus_c.sck;
  end

  int         t_vcnt = 0;
  logic [0:0] t_chs [4];
  always @(negedge clk) begin
    if (rst_n && valid_t) begin
      if (t_vcnt < 4) t_chs[t_vcnt] = ch_t;
      t_vcnt++;
    end
  end

  task automatic wait_valid_c(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid_c) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ncs_c(input bit want_low, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((bus_c.ncs != 2'b11) == want_low) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int vsnap, esnap;
    rst_n = 1'b1; en_c = 1'b0; en_t = 1'b0; trig_c = 1'b0; trig_t = 1'b0;
    bus_c.sdo = 1'b0; bus_t.sdo = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ncs", 32'(bus_c.ncs), 32'h3);
    check("rst_sck", 32'(bus_c.sck), 32'h1);
    check("rst_data", 32'(data_c), 32'h0);
    check("rst_busy", 32'(busy_c), 32'h0);
    check("rst_valid", 32'(valid_c), 32'h0);
    check("rst_ch", 32'(ch_c), 32'h0);
    check("rst_trig_ncs", 32'(bus_t.ncs), 32'h3);
    check("rst_trig_data", 32'(data_t), 32'h0);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_sck_edges", 32'(sck_edges), 32'h0);
    check("idle_busy", 32'(busy_c), 32'h0);
    check("idle_ncs", 32'(bus_c.ncs), 32'h3);

    // Continuous scan: ch0 then ch1
    en_c = 1'b1;
    wait_valid_c(300, ok);
    check("f0_seen", 32'(ok), 32'h1);
    check("f0_ch", 32'(ch_c), 32'h0);
    check("f0_data", 32'(data_c[7:0]), 32'hA5);
    check("f0_latency", 32'(cyc - fall_cyc), 32'd136);
    wait_valid_c(300, ok);
    check("f1_seen", 32'(ok), 32'h1);
    check("f1_ch", 32'(ch_c), 32'h1);
    check("f1_data", 32'(data_c), 32'h5FA5);
    check("f1_latency", 32'(cyc - fall_cyc), 32'd136);
    check("f1_spacing", 32'(fall_cyc - fall_prev), 32'd161);

    // enable drops mid-frame on ch0 with a new ch0 value
    fc0 = 16'h1FE0;
    wait_ncs_c(1'b1, 100, ok);
    check("f2_start", 32'(ok), 32'h1);
    check("f2_ncs", 32'(bus_c.ncs), 32'h2);
    repeat (44) @(negedge clk);
    check("f2_mid_busy", 32'(busy_c), 32'h1);
    en_c = 1'b0;
    wait_valid_c(200, ok);
    check("f2_seen", 32'(ok), 32'h1);
    check("f2_ch", 32'(ch_c), 32'h0);
    check("f2_data", 32'(data_c), 32'h5FFF);
    check("f2_latency", 32'(cyc - fall_cyc), 32'd136);
    check("f2_spacing", 32'(fall_cyc - fall_prev), 32'd161);
    repeat (26) @(negedge clk);
    check("drop_idle_busy", 32'(busy_c), 32'h0);
    check("drop_idle_ncs", 32'(bus_c.ncs), 32'h3);
    vsnap = c_vcnt;
    esnap = sck_edges;
    repeat (200) @(negedge clk);
    check("drop_no_valid", 32'(c_vcnt), 32'(vsnap));
    check("drop_no_sck", 32'(sck_edges), 32'(esnap));

    // Bus protocol summary over the three completed frames
    check("proto_windows", 32'(windows), 32'd3);
    check("proto_16_rises", 32'(bad_win), 32'h0);
    check("proto_one_ncs", 32'(ncs00), 32'h0);
    check("proto_ncs_sck_high", 32'(viol), 32'h0);

    // Re-enable resumes at ch1
    en_c = 1'b1;
    wait_ncs_c(1'b1, 20, ok);
    check("resume_start", 32'(ok), 32'h1);
    check("resume_ncs", 32'(bus_c.ncs), 32'h1);

    // Trigger mode
    en_t = 1'b1;
    repeat (5) @(negedge clk);
    check("trig_enable_only_idle", 32'(busy_t), 32'h0);
    trig_t = 1'b1;
    @(negedge clk);
    trig_t = 1'b0;
    check("trig_busy", 32'(busy_t), 32'h1);
    repeat (50) @(negedge clk);
    check("trig_busy_retrigger", 32'(busy_t), 32'h1);
    trig_t = 1'b1;
    @(negedge clk);
    trig_t = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (!busy_t) begin
        ok = 1'b1;
        break;
      end
    end
    check("trig_done", 32'(ok), 32'h1);
    check("trig_count", 32'(t_vcnt), 32'd2);
    check("trig_ch_first", 32'(t_chs[0]), 32'h0);
    check("trig_ch_second", 32'(t_chs[1]), 32'h1);
    check("trig_data", 32'(data_t), 32'h5FA5);
    repeat (300) @(negedge clk);
    check("trig_no_extra", 32'(t_vcnt), 32'd2);
    check("trig_stays_idle", 32'(busy_t), 32'h0);
    en_t = 1'b0;
    trig_t = 1'b1;
    @(negedge clk);
    trig_t = 1'b0;
    repeat (20) @(negedge clk);
    check("trig_disabled_idle", 32'(busy_t), 32'h0);
    check("trig_disabled_count", 32'(t_vcnt), 32'd2);

    // Reset in the middle of a shift
    wait_ncs_c(1'b0, 200, ok);
    check("rst6_gap", 32'(ok), 32'h1);
    wait_ncs_c(1'b1, 200, ok);
    check("rst6_frame", 32'(ok), 32'h1);
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst6_ncs", 32'(bus_c.ncs), 32'h3);
    check("rst6_sck", 32'(bus_c.sck), 32'h1);
    check("rst6_data", 32'(data_c), 32'h0);
    check("rst6_busy", 32'(busy_c), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_valid_c(300, ok);
    check("rst6_seen", 32'(ok), 32'h1);
    check("rst6_ch", 32'(ch_c), 32'h0);
    check("rst6_result", 32'(data_c), 32'h00FF);
    check("rst6_latency", 32'(cyc - fall_cyc), 32'd136);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
